// File: rtl/mult_issue_ctrl_if.sv
// Signal bundle between the execute stage, the issue controller and the Booth multiplier.
// The slave modport is the controller's view; the master modport is the surrounding pipeline and multiplier.
interface mult_issue_ctrl_if #(
   parameter int CNT_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic [31:0]       req_a;
   logic [31:0]       req_b;
   logic [4:0]        req_tag;
   logic              flush;
   logic              mult_ctrl;
   logic [31:0]       mult_a;
   logic [31:0]       mult_b;
   logic [31:0]       mult_result;
   logic              mult_ready;
   logic              mult_exception;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_result;
   logic              resp_exception;
   logic              resp_timeout;
   logic [4:0]        resp_tag;
   logic              stall;
   logic [CNT_W-1:0]  op_count;

   modport slave (
      input  req_valid, req_a, req_b, req_tag, flush,
             mult_result, mult_ready, mult_exception, resp_ready,
      output req_ready, mult_ctrl, mult_a, mult_b,
             resp_valid, resp_result, resp_exception, resp_timeout, resp_tag,
             stall, op_count
   );

   modport master (
      output req_valid, req_a, req_b, req_tag, flush,
             mult_result, mult_ready, mult_exception, resp_ready,
      input  req_ready, mult_ctrl, mult_a, mult_b,
             resp_valid, resp_result, resp_exception, resp_timeout, resp_tag,
             stall, op_count
   );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Issue/sequencing front-end for the radix-4 Booth multiplier: holds operands, pulses start,
// waits for ready (with stale-ready guard and hang timeout) and returns a registered response.
module mult_issue_ctrl #(
   parameter int MIN_WAIT = 2,
   parameter int TIMEOUT  = 64,
   parameter int CNT_W    = 16
) (
   input  logic            clk,
   input  logic            reset,
   mult_issue_ctrl_if.slave bus
);
   localparam int WC_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   state_t           state;
   logic [WC_W-1:0]  wait_cnt;
   logic [31:0]      a_q;
   logic [31:0]      b_q;
   logic [4:0]       tag_q;
   logic             ctrl_q;
   logic             vld_q;
   logic [31:0]      res_q;
   logic             exc_q;
   logic             tmo_q;
   logic [4:0]       rtag_q;
   logic [CNT_W-1:0] cnt_q;
   logic             req_ready;
   logic             accept;
   logic             honour;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign req_ready = ((state == IDLE) || ((state == DONE) && bus.resp_ready)) && !bus.flush;
   assign accept    = bus.req_valid && req_ready;
   // Ready seen in the first MIN_WAIT wait cycles may still belong to the previous operation.
   assign honour    = bus.mult_ready && (wait_cnt >= WC_W'(MIN_WAIT));

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         a_q      <= '0;
         b_q      <= '0;
         tag_q    <= '0;
         ctrl_q   <= 1'b0;
         vld_q    <= 1'b0;
         res_q    <= '0;
         exc_q    <= 1'b0;
         tmo_q    <= 1'b0;
         rtag_q   <= '0;
         cnt_q    <= '0;
      end else begin
         ctrl_q <= 1'b0;
         if (accept) begin
            a_q    <= bus.req_a;
            b_q    <= bus.req_b;
            tag_q  <= bus.req_tag;
            ctrl_q <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (accept) state <= START;
            end
            START: begin
               wait_cnt <= '0;
               state    <= bus.flush ? IDLE : WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + WC_W'(1);
               if (bus.flush) begin
                  state <= IDLE;
               end else if (honour) begin
                  res_q  <= bus.mult_result;
                  exc_q  <= bus.mult_exception;
                  tmo_q  <= 1'b0;
                  rtag_q <= tag_q;
                  vld_q  <= 1'b1;
                  state  <= DONE;
               end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                  res_q  <= '0;
                  exc_q  <= 1'b1;
                  tmo_q  <= 1'b1;
                  rtag_q <= tag_q;
                  vld_q  <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (bus.flush) begin
                  vld_q <= 1'b0;
                  state <= IDLE;
               end else if (bus.resp_ready) begin
                  vld_q <= 1'b0;
                  cnt_q <= sat_inc(cnt_q);
                  state <= accept ? START : IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready      = req_ready;
   assign bus.mult_ctrl      = ctrl_q;
   assign bus.mult_a         = a_q;
   assign bus.mult_b         = b_q;
   assign bus.resp_valid     = vld_q;
   assign bus.resp_result    = res_q;
   assign bus.resp_exception = exc_q;
   assign bus.resp_timeout   = tmo_q;
   assign bus.resp_tag       = rtag_q;
   assign bus.stall          = (state == START) || (state == WAIT);
   assign bus.op_count       = cnt_q;
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl: table of multiply vectors plus hand sequences for backpressure,
// stale ready/timeout, flush, reset and back-to-back issue; responses checked through a scoreboard.
module tb_mult_issue_ctrl;
   localparam int MIN_WAIT = 2;
   localparam int TIMEOUT  = 64;
   localparam int CNT_W    = 16;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  tag;
      logic [31:0] r;
      logic        e;
   } vec_t;

   typedef struct {
      logic [31:0] r;
      logic        e;
      logic        t;
      logic [4:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_issue_ctrl_if #(.CNT_W(CNT_W)) bus();

   mult_issue_ctrl #(.MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb[$];
   exp_t mon_e;

   // Multiplier stand-in: ready 18 cycles after the clear pulse, held until the next pulse.
   int                 mdl_cnt = 0;
   logic               mdl_rdy = 1'b0;
   logic [31:0]        mdl_res = '0;
   logic               mdl_exc = 1'b0;
   int                 rdy_ovr = 0;
   logic signed [63:0] prod;

   assign prod = $signed(bus.mult_a) * $signed(bus.mult_b);

   always @(posedge clk) begin
      if (bus.mult_ctrl) begin
         mdl_cnt <= 18;
         mdl_rdy <= 1'b0;
      end else if (mdl_cnt > 0) begin
         mdl_cnt <= mdl_cnt - 1;
         if (mdl_cnt == 1) begin
            mdl_rdy <= 1'b1;
            mdl_res <= prod[31:0];
            mdl_exc <= (prod != {{32{prod[31]}}, prod[31:0]});
         end
      end
   end

   assign bus.mult_ready     = (rdy_ovr == 0) ? mdl_rdy : (rdy_ovr == 1);
   assign bus.mult_result    = mdl_res;
   assign bus.mult_exception = mdl_exc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                        input bit push, input exp_t e);
      bus.req_valid = 1'b1;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_tag   = tag;
      if (push) sb.push_back(e);
      #1;
      check("req_ready_at_issue", bus.req_ready, 1);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_valid(inout int lat);
      while (!bus.resp_valid && lat < 300) begin
         step();
         lat++;
      end
      check("resp_valid_wait", bus.resp_valid, 1);
   endtask

   // Scoreboard: every handshaken response is popped and compared.
   always @(negedge clk) begin
      if (!reset && bus.resp_valid && bus.resp_ready) begin
         if (sb.size() == 0) begin
            check("resp_unexpected", bus.resp_valid, 0);
         end else begin
            mon_e = sb.pop_front();
            check("resp_result", bus.resp_result, mon_e.r);
            check("resp_exception", bus.resp_exception, mon_e.e);
            check("resp_timeout", bus.resp_timeout, mon_e.t);
            check("resp_tag", bus.resp_tag, mon_e.tag);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      exp_t e;
      int   lat;
      bit   seen;

      tbl[0] = '{32'd7,        32'd6,        5'd3,  32'd42,       1'b0};
      tbl[1] = '{32'h80000000, 32'hFFFFFFFF, 5'd1,  32'h80000000, 1'b1};
      tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000001, 1'b0};
      tbl[3] = '{32'h00010000, 32'h00010000, 5'd4,  32'h00000000, 1'b1};
      tbl[4] = '{32'h7FFFFFFF, 32'h00000002, 5'd31, 32'hFFFFFFFE, 1'b1};

      reset = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_tag    = '0;
      bus.flush      = 1'b0;
      bus.resp_ready = 1'b1;
      repeat (3) step();

      check("rst_req_ready", bus.req_ready, 1);
      check("rst_mult_ctrl", bus.mult_ctrl, 0);
      check("rst_mult_a", bus.mult_a, 0);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_op_count", bus.op_count, 0);
      reset = 1'b0;
      step();

      // ---- table-driven multiplies
      for (int i = 0; i < 5; i++) begin
         e = '{tbl[i].r, tbl[i].e, 1'b0, tbl[i].tag};
         issue(tbl[i].a, tbl[i].b, tbl[i].tag, 1'b1, e);
         check("start_ctrl", bus.mult_ctrl, 1);
         check("start_a", bus.mult_a, tbl[i].a);
         check("start_b", bus.mult_b, tbl[i].b);
         check("start_stall", bus.stall, 1);
         step();
         check("ctrl_one_cycle", bus.mult_ctrl, 0);
         lat = 1;
         wait_valid(lat);
         if (i == 0) check("latency", lat, 20);
         step();
         check("resp_drop", bus.resp_valid, 0);
         if (i == 0) check("op_count_first", bus.op_count, 1);
      end

      // ---- signed multiply held under backpressure
      bus.resp_ready = 1'b0;
      e = '{32'hFFFFFFF1, 1'b0, 1'b0, 5'd7};
      issue(32'hFFFFFFFD, 32'd5, 5'd7, 1'b1, e);
      lat = 0;
      wait_valid(lat);
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", bus.resp_valid, 1);
         check("bp_result", bus.resp_result, 32'hFFFFFFF1);
         check("bp_req_ready", bus.req_ready, 0);
         step();
      end
      bus.resp_ready = 1'b1;
      step();
      check("bp_op_count", bus.op_count, 6);

      // ---- stale ready ignored, then hang timeout
      rdy_ovr = 1;
      e = '{32'd0, 1'b1, 1'b1, 5'd9};
      issue(32'h1234, 32'h10, 5'd9, 1'b1, e);
      repeat (3) step();
      check("stale_ignored", bus.resp_valid, 0);
      rdy_ovr = 2;
      lat = 3;
      wait_valid(lat);
      check("timeout_latency", lat, TIMEOUT + 1);
      step();
      rdy_ovr = 0;
      check("timeout_op_count", bus.op_count, 7);

      // ---- flush five cycles into WAIT
      e = '{32'd81, 1'b0, 1'b0, 5'd5};
      issue(32'd9, 32'd9, 5'd5, 1'b0, e);
      repeat (6) step();
      bus.flush = 1'b1;
      #1;
      check("flush_blocks_accept", bus.req_ready, 0);
      step();
      bus.flush = 1'b0;
      #1;
      check("flush_req_ready", bus.req_ready, 1);
      check("flush_stall", bus.stall, 0);
      check("flush_op_count", bus.op_count, 7);
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (bus.resp_valid) seen = 1'b1;
         step();
      end
      check("flush_no_resp", seen, 0);

      // ---- reset mid-WAIT
      issue(32'd3, 32'd3, 5'd6, 1'b0, e);
      repeat (4) step();
      reset = 1'b1;
      step();
      check("mrst_mult_ctrl", bus.mult_ctrl, 0);
      check("mrst_mult_a", bus.mult_a, 0);
      check("mrst_mult_b", bus.mult_b, 0);
      check("mrst_resp_valid", bus.resp_valid, 0);
      check("mrst_resp_result", bus.resp_result, 0);
      check("mrst_resp_exception", bus.resp_exception, 0);
      check("mrst_resp_timeout", bus.resp_timeout, 0);
      check("mrst_resp_tag", bus.resp_tag, 0);
      check("mrst_stall", bus.stall, 0);
      check("mrst_op_count", bus.op_count, 0);
      check("mrst_req_ready", bus.req_ready, 1);
      reset = 1'b0;
      step();

      // ---- back-to-back: new request in the same cycle as the handshake
      bus.resp_ready = 1'b0;
      e = '{32'd6, 1'b0, 1'b0, 5'd1};
      issue(32'd2, 32'd3, 5'd1, 1'b1, e);
      lat = 0;
      wait_valid(lat);
      bus.resp_ready = 1'b1;
      e = '{32'd20, 1'b0, 1'b0, 5'd2};
      issue(32'd4, 32'd5, 5'd2, 1'b1, e);
      check("b2b_ctrl", bus.mult_ctrl, 1);
      check("b2b_mult_a", bus.mult_a, 4);
      check("b2b_resp_drop", bus.resp_valid, 0);
      check("b2b_op_count_1", bus.op_count, 1);
      step();
      check("b2b_ctrl_width", bus.mult_ctrl, 0);
      lat = 1;
      wait_valid(lat);
      step();
      check("b2b_op_count_2", bus.op_count, 2);
      check("b2b_resp_drop2", bus.resp_valid, 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
